regfile_mp: RTL and testbench

Parametrised multi-port register file, the successor to the single-cycle processor's 2-read/1-write register file. Provides NRD asynchronous read ports and two synchronous write ports, plus a hardwired zero register. A reset-initialisation sequencer loads every entry after reset, so no simulation-only initial blocks are needed. Sits in the decode stage of the single-cycle and pipelined datapaths.

---
 rtl/regfile_mp.sv | 125 ++++++++++++
 tb/tb_regfile_mp.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised register file with NRD combinational read ports
// and two synchronous write ports. Port 1 has priority over port 0 when both
// write the same entry. One entry (ZERO_REG) is hardwired to zero.
//
// After reset a sequencer fills every entry with its own index. The zero
// register is filled with 0. While the sequencer runs, init_busy is high,
// all writes are ignored and every read port returns 0. The array itself has
// no reset; the sequencer takes care of initialising it.
//
// Optional feature, enabled by defining REGFILE_MP_BYPASS_EN:
//   Same-cycle write-through forwarding from the write ports to any read
//   port reading the same address. Port 1 has priority over port 0, and the
//   zero register always reads 0. When the macro is not defined, a write
//   shows up on rd in the cycle after the clock edge that commits it.
module regfile_mp #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 31
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NRD*ADDR_W-1:0]    ra,
  output logic [NRD*DATA_W-1:0]    rd,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        wa0,
  input  logic [DATA_W-1:0]        wd0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        wa1,
  input  logic [DATA_W-1:0]        wd1,
  output logic                     init_busy
);

  localparam int NREG = 2**ADDR_W;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [ADDR_W-1:0] ZADDR    = ADDR_W'(ZERO_REG);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREG - 1);

  logic [0:0]        state;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] mem [NREG];

  logic running;
  logic wr0Ok;
  logic wr1Ok;

  assign running   = (state == ST_RUN);
  assign init_busy = (state == ST_INIT);

  // Port 1 always commits when it is enabled and is not aimed at the zero
  // register. Port 0 is dropped when port 1 writes the same entry, so
  // port 1 wins the conflict.
  assign wr1Ok = we1 && (wa1 != ZADDR);
  assign wr0Ok = we0 && (wa0 != ZADDR) && !(we1 && (wa1 == wa0));

  // Init sequencer: walk cnt over every entry once, then switch to RUN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else if (state == ST_INIT) begin
      cnt <= cnt + ADDR_W'(1);
      if (cnt == LAST_IDX) begin
        state <= ST_RUN;
      end
    end
  end

  // Array update: index fill during INIT, the two write ports during RUN
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      if (cnt == ZADDR) begin
        mem[cnt] <= '0;
      end else begin
        mem[cnt] <= DATA_W'(cnt);
      end
    end else begin
      if (wr0Ok) begin
        mem[wa0] <= wd0;
      end
      if (wr1Ok) begin
        mem[wa1] <= wd1;
      end
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] portData;

    assign addr = ra[k*ADDR_W +: ADDR_W];

    // Read mux: forced to 0 during INIT and for the zero register
    always_comb begin
      portData = '0;
      if (running && (addr != ZADDR)) begin
`ifdef REGFILE_MP_BYPASS_EN
        if (we1 && (wa1 == addr)) begin
          portData = wd1;
        end else if (we0 && (wa0 == addr)) begin
          portData = wd0;
        end else begin
          portData = mem[addr];
        end
`else
        portData = mem[addr];
`endif
      end
    end

    assign rd[k*DATA_W +: DATA_W] = portData;
  end

  // Flag unknown write enables in RUN; the write logic treats them as no write
  always @(posedge clk) begin
    if (rst_n && running) begin
      assert (!$isunknown({we0, we1}))
        else $error("regfile_mp: unknown write enable in RUN");
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed test of regfile_mp with default parameters
// (64-bit data, 32 entries, 2 read ports, zero register 31). The expected
// values are worked out by hand. They are selected with REGFILE_MP_BYPASS_EN
// wherever forwarding changes what a read returns in the same cycle.
module tb_regfile_mp;

  localparam int DW = 64;
  localparam int AW = 5;

  logic            clk;
  logic            rst_n;
  logic [2*AW-1:0] ra;
  logic [2*DW-1:0] rd;
  logic            we0;
  logic [AW-1:0]   wa0;
  logic [DW-1:0]   wd0;
  logic            we1;
  logic [AW-1:0]   wa1;
  logic [DW-1:0]   wd1;
  logic            init_busy;

  int nAsserts = 0;
  int nFails   = 0;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NRD(2), .ZERO_REG(31)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ra        (ra),
    .rd        (rd),
    .we0       (we0),
    .wa0       (wa0),
    .wd0       (wd0),
    .we1       (we1),
    .wa1       (wa1),
    .wd1       (wd1),
    .init_busy (init_busy)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive both write ports and both read addresses (port 1 in the upper bits)
  task automatic applyStimulus(input logic e0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                               input logic e1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                               input logic [AW-1:0] r0, input logic [AW-1:0] r1);
    we0 = e0; wa0 = a0; wd0 = d0;
    we1 = e1; wa1 = a1; wd1 = d1;
    ra  = {r1, r0};
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [2*DW-1:0] observed,
                             input logic [2*DW-1:0] expected);
    nAsserts++;
    assert (observed === expected)
      else begin
        nFails++;
        $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
  endtask

  // Release reset, then expect exactly 32 cycles of init_busy with rd forced to 0
  task automatic runInit(input string tag);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 32; i++) begin
      checkOutput({tag, "_busy"}, 128'(init_busy), 128'(1));
      checkOutput({tag, "_rdzero"}, rd, '0);
      tick();
    end
    checkOutput({tag, "_done"}, 128'(init_busy), 128'(0));
  endtask

  initial begin
    $display("[TB] start");
    rst_n = 1'b0;
    we0 = 1'b0; wa0 = '0; wd0 = '0;
    we1 = 1'b0; wa1 = '0; wd1 = '0;
    ra  = {5'd5, 5'd3};
    #1;
    checkOutput("reset_busy", 128'(init_busy), 128'(1));
    checkOutput("reset_rd", rd, '0);
    tick();
    tick();

    // Power-up init sequence
    runInit("init1");
    applyStimulus(0, 0, 0, 0, 0, 0, 5'd5, 5'd30);
    checkOutput("init_x5_x30", rd, {64'd30, 64'd5});
    applyStimulus(0, 0, 0, 0, 0, 0, 5'd31, 5'd0);
    checkOutput("init_x31_x0", rd, {64'd0, 64'd0});
    applyStimulus(0, 0, 0, 0, 0, 0, 5'd1, 5'd17);
    checkOutput("init_x1_x17", rd, {64'd17, 64'd1});

    // Basic write and read, plus the same-cycle view of that write
    applyStimulus(1, 5'd3, 64'hDEAD_BEEF_0000_0001, 0, 0, 0, 5'd3, 5'd4);
`ifdef REGFILE_MP_BYPASS_EN
    checkOutput("wr_samecycle", rd, {64'd4, 64'hDEAD_BEEF_0000_0001});
`else
    checkOutput("wr_samecycle", rd, {64'd4, 64'd3});
`endif
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 5'd3, 5'd4);
    checkOutput("wr_basic", rd, {64'd4, 64'hDEAD_BEEF_0000_0001});

    // Zero register: the write is discarded and reads return 0
    applyStimulus(0, 0, 0, 1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 5'd31);
    checkOutput("zero_samecycle", rd, '0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 5'd31, 5'd31);
    checkOutput("zero_after", rd, '0);

    // Both ports write the same entry: port 1 wins
    applyStimulus(1, 5'd7, 64'h11, 1, 5'd7, 64'h22, 5'd7, 5'd6);
`ifdef REGFILE_MP_BYPASS_EN
    checkOutput("conflict_samecycle", rd, {64'd6, 64'h22});
`else
    checkOutput("conflict_samecycle", rd, {64'd6, 64'd7});
`endif
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 5'd7, 5'd6);
    checkOutput("conflict", rd, {64'd6, 64'h22});

    // Both ports write different entries in the same cycle
    applyStimulus(1, 5'd8, 64'h33, 1, 5'd9, 64'h44, 5'd8, 5'd9);
`ifdef REGFILE_MP_BYPASS_EN
    checkOutput("dual_samecycle", rd, {64'h44, 64'h33});
`else
    checkOutput("dual_samecycle", rd, {64'd9, 64'd8});
`endif
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 5'd8, 5'd9);
    checkOutput("dual", rd, {64'h44, 64'h33});

    // Forwarding is address-qualified: port 1 reads a neighbouring entry
    applyStimulus(1, 5'd12, 64'h55, 0, 0, 0, 5'd12, 5'd13);
`ifdef REGFILE_MP_BYPASS_EN
    checkOutput("bypass_same", rd, {64'd13, 64'h55});
`else
    checkOutput("bypass_same", rd, {64'd13, 64'd12});
`endif
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 5'd12, 5'd13);
    checkOutput("bypass_next", rd, {64'd13, 64'h55});

    // Reset asserted partway through INIT restarts the sequence
    rst_n = 1'b0;
    tick();
    runInit("midinit_pre");
    applyStimulus(0, 0, 0, 0, 0, 0, 5'd3, 5'd12);
    checkOutput("run_restored", rd, {64'd12, 64'd3});
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    rst_n = 1'b0;
    #1;
    checkOutput("midinit_busy", 128'(init_busy), 128'(1));
    checkOutput("midinit_rd", rd, '0);
    tick();
    runInit("midinit");
    applyStimulus(0, 0, 0, 0, 0, 0, 5'd10, 5'd20);
    checkOutput("midinit_vals", rd, {64'd20, 64'd10});

    // Reset during RUN wipes a previous write back to the index value
    applyStimulus(1, 5'd3, 64'hAB, 0, 0, 0, 5'd3, 5'd0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 5'd3, 5'd0);
    checkOutput("run_wr_ab", rd, {64'd0, 64'hAB});
    rst_n = 1'b0;
    #1;
    checkOutput("run_reset_busy", 128'(init_busy), 128'(1));
    tick();
    runInit("runreset");
    applyStimulus(0, 0, 0, 0, 0, 0, 5'd3, 5'd31);
    checkOutput("runreset_x3", rd, {64'd0, 64'd3});

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
